// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline step controller and the pipeline latches it drives.
// The mode encodings must match what the IF/ID, ID/EX, EX/MEM and MEM/WB latches compare against.
package pipeline_ctrl_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_CONT = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      ST_RUN:                     return MODE_CONT;
      ST_STEP_WAIT, ST_STEP_EXEC: return MODE_STEP;
      default:                    return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Rising-edge detector for the debug unit's step request level.
// The first sample after reset only arms the detector, so a level already high is not a step.
module step_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q & level_i & ~prev_q;

endmodule

// File: rtl/pipeline_step_controller.sv
// Debug-unit sequencer for the pipeline latches: continuous or single-step advance,
// EOF drain-and-freeze, saturating advance counter and a watchdog on runaway programs.
module pipeline_step_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_CYCLES  = 32,
  parameter int unsigned MAX_CYCLES = 2**20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start_cont,
  input  logic                 i_start_step,
  input  logic                 i_step_req,
  input  logic                 i_eof_wb,
  input  logic                 i_clear,
  output logic [1:0]           o_pipeline_mode,
  output logic                 o_execute_instruct,
  output logic                 o_busy,
  output logic                 o_halted,
  output logic                 o_timeout,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  localparam logic [NB_CYCLES-1:0] WD_LIMIT = NB_CYCLES'(MAX_CYCLES - 1);
  localparam logic [NB_CYCLES-1:0] CNT_ONE  = {{(NB_CYCLES-1){1'b0}}, 1'b1};
  localparam logic [NB_CYCLES-1:0] CNT_MAX  = '1;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic                  exec_q, exec_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  timeout_q, timeout_d;
  logic                  pending_q, pending_d;
  logic [NB_CYCLES-1:0]  count_q, count_d;
  logic                  step_rise;
  logic                  advance;
  logic                  wd_hit;

  step_edge_detect u_step_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .level_i (i_step_req),
    .rise_o  (step_rise)
  );

  // Outputs mirror state_q, so "latches advanced this cycle" is RUN or STEP_EXEC.
  always_comb begin
    advance = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC);
    wd_hit  = advance && (count_q == WD_LIMIT);
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    pending_d = pending_q;
    count_d   = count_q;

    if (advance && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        pending_d = 1'b0;
        if (i_start_cont) begin
          state_d = ST_RUN;
        end else if (i_start_step) begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_RUN: begin
        if (i_eof_wb) begin
          state_d = ST_HALTED;
        end else if (wd_hit) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end
      end
      ST_STEP_WAIT: begin
        if (i_eof_wb) begin
          state_d = ST_HALTED;
        end else if (step_rise || pending_q) begin
          state_d   = ST_STEP_EXEC;
          pending_d = 1'b0;
        end
      end
      ST_STEP_EXEC: begin
        // Only one step can be queued behind the one executing now.
        if (step_rise) begin
          pending_d = 1'b1;
        end
        if (i_eof_wb) begin
          state_d = ST_HALTED;
        end else if (wd_hit) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_HALTED: begin
        if (i_clear) begin
          state_d   = ST_IDLE;
          count_d   = '0;
          timeout_d = 1'b0;
          pending_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mode_d   = mode_of(state_d);
    exec_d   = (state_d == ST_STEP_EXEC);
    busy_d   = (state_d == ST_RUN) || (state_d == ST_STEP_WAIT) || (state_d == ST_STEP_EXEC);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_HOLD;
      exec_q    <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      pending_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      exec_q    <= exec_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign o_pipeline_mode    = mode_q;
  assign o_execute_instruct = exec_q;
  assign o_busy             = busy_q;
  assign o_halted           = halted_q;
  assign o_timeout          = timeout_q;
  assign o_cycle_count      = count_q;

endmodule
